// File: rtl/quadrilatero_rd_streamer_if.sv
// Bundle of the command, sequencer read-port and row-output channels of the
// read streamer. master = streamer side, slave = environment/sequencer side.
interface quadrilatero_rd_streamer_if #(
  parameter int unsigned N_REGS    = 8,
  parameter int unsigned N_ROWS    = 4,
  parameter int unsigned RLEN      = 128,
  parameter int unsigned ID_WIDTH  = 4
) ();
  localparam int unsigned RegW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned RowW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned NrW  = $clog2(N_ROWS) + 1;

  // Command channel
  logic                cmd_valid;
  logic                cmd_ready;
  logic [RegW-1:0]     cmd_reg;
  logic [ID_WIDTH-1:0] cmd_id;
  logic [NrW-1:0]      cmd_nrows;

  // Sequencer read port
  logic [RegW-1:0]     raddr;
  logic [RowW-1:0]     rrowaddr;
  logic [ID_WIDTH-1:0] rd_id;
  logic                rready;
  logic                rlast;
  logic                rvalid;
  logic [RLEN-1:0]     rdata;

  // Row output toward the consuming FU
  logic                row_valid;
  logic                row_ready;
  logic [RLEN-1:0]     row_data;
  logic [RowW-1:0]     row_idx;
  logic                row_last;

  modport master (
    input  cmd_valid, cmd_reg, cmd_id, cmd_nrows, rvalid, rdata, row_ready,
    output cmd_ready, raddr, rrowaddr, rd_id, rready, rlast,
           row_valid, row_data, row_idx, row_last
  );

  modport slave (
    output cmd_valid, cmd_reg, cmd_id, cmd_nrows, rvalid, rdata, row_ready,
    input  cmd_ready, raddr, rrowaddr, rd_id, rready, rlast,
           row_valid, row_data, row_idx, row_last
  );
endinterface

// File: rtl/quadrilatero_rd_streamer.sv
// Read-port front end for one functional unit: walks the rows of one matrix
// register through the RF sequencer read port and buffers them in a small FIFO.
// Optional stall counter enabled by QUADRILATERO_RD_STREAMER_STATS_EN.
module quadrilatero_rd_streamer #(
  parameter int unsigned N_REGS    = 8,
  parameter int unsigned N_ROWS    = 4,
  parameter int unsigned RLEN      = 128,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  quadrilatero_rd_streamer_if.master  bus_io,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [15:0]                 stall_cycles_o
);
  localparam int unsigned RegW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned RowW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned NrW  = $clog2(N_ROWS) + 1;
  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e              state_q;
  logic [RegW-1:0]     reg_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [NrW-1:0]      nrows_q;
  logic [RowW-1:0]     row_cnt_q;

  logic [RLEN-1:0]      data_mem_q [OUT_DEPTH];
  logic [RowW-1:0]      idx_mem_q  [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] last_mem_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;

  logic accept, is_last, rready, grant, row_valid, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode; rready uses the pre-pop count so a full FIFO blocks requests.
  always_comb begin
    accept    = (state_q == StIdle) & bus_io.cmd_valid;
    is_last   = (NrW'(row_cnt_q) == nrows_q - NrW'(1));
    rready    = (state_q == StReq) & (cnt_q < CntW'(OUT_DEPTH));
    grant     = rready & bus_io.rvalid;
    row_valid = (cnt_q != '0);
    pop       = row_valid & bus_io.row_ready;
  end

  // Command FSM and row walker; the counter stops at nrows-1 so it never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      reg_q     <= '0;
      id_q      <= '0;
      nrows_q   <= '0;
      row_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            reg_q     <= bus_io.cmd_reg;
            id_q      <= bus_io.cmd_id;
            nrows_q   <= (bus_io.cmd_nrows == '0) ? NrW'(N_ROWS) : bus_io.cmd_nrows;
            row_cnt_q <= '0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (grant) begin
            if (is_last) state_q   <= StDrain;
            else         row_cnt_q <= row_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (cnt_q == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO: circular buffer whose head entry drives the row outputs directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        idx_mem_q[i]  <= '0;
      end
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (grant) begin
        data_mem_q[wr_ptr_q] <= bus_io.rdata;
        idx_mem_q[wr_ptr_q]  <= row_cnt_q;
        last_mem_q[wr_ptr_q] <= is_last;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(grant) - CntW'(pop);
    end
  end

`ifdef QUADRILATERO_RD_STREAMER_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of request cycles the sequencer left ungranted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (rready && !bus_io.rvalid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

  assign bus_io.cmd_ready = (state_q == StIdle);
  assign bus_io.raddr     = reg_q;
  assign bus_io.rrowaddr  = row_cnt_q;
  assign bus_io.rd_id     = id_q;
  assign bus_io.rready    = rready;
  assign bus_io.rlast     = rready & is_last;
  assign bus_io.row_valid = row_valid;
  assign bus_io.row_data  = data_mem_q[rd_ptr_q];
  assign bus_io.row_idx   = idx_mem_q[rd_ptr_q];
  assign bus_io.row_last  = last_mem_q[rd_ptr_q];
  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDrain) & (cnt_q == '0);

endmodule

// File: tb/tb_quadrilatero_rd_streamer.sv
// Directed bench for quadrilatero_rd_streamer with default parameters.
// The sequencer is modelled as a register file returning pat(reg, row).
module tb_quadrilatero_rd_streamer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        busy_o, done_o;
  logic [15:0] stall_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;
  int grants   = 0;
  logic [2:0] cur_reg = '0;
  logic [1:0] pop_idx [$];

  quadrilatero_rd_streamer_if #(
    .N_REGS(8), .N_ROWS(4), .RLEN(128), .ID_WIDTH(4)
  ) bus ();

  quadrilatero_rd_streamer #(
    .N_REGS(8), .N_ROWS(4), .RLEN(128), .ID_WIDTH(4), .OUT_DEPTH(2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bus_io         (bus),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] pat(input logic [2:0] r, input logic [1:0] row);
    return {29'h0, r, 30'h0, row, 32'hC0DE_0000 | {30'h0, row}, 32'hDEAD_0000 | {29'h0, r}};
  endfunction

  // Sequencer register-file model
  always_comb bus.rdata = pat(bus.raddr, bus.rrowaddr);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else cyc();
    end
    check(tag, {127'h0, seen}, 128'd1);
  endtask

  task automatic issue(input logic [2:0] r, input logic [3:0] id, input logic [2:0] nr);
    bus.cmd_valid = 1'b1;
    bus.cmd_reg   = r;
    bus.cmd_id    = id;
    bus.cmd_nrows = nr;
    cur_reg       = r;
  endtask

  // Row and grant monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    if (!rst_i && bus.row_valid && bus.row_ready) begin
      check("row_data", bus.row_data, pat(cur_reg, bus.row_idx));
      pop_idx.push_back(bus.row_idx);
    end
    if (!rst_i && bus.rready && bus.rvalid) grants++;
  end

  initial begin
    rst_i         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_reg   = '0;
    bus.cmd_id    = '0;
    bus.cmd_nrows = '0;
    bus.rvalid    = 1'b0;
    bus.row_ready = 1'b0;
    repeat (2) cyc();

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rready", bus.rready, 0);
    check("rst_row_valid", bus.row_valid, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_stall", stall_cycles_o, 0);
    rst_i = 1'b0;
    cyc();

    // Test 1: full 4-row read at one row per cycle
    pop_idx.delete();
    bus.rvalid = 1'b1;
    bus.row_ready = 1'b1;
    issue(3'd3, 4'd5, 3'd0);
    check("t1_cmd_ready", bus.cmd_ready, 1);
    cyc();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t1_rrowaddr", bus.rrowaddr, i);
      check("t1_rlast", bus.rlast, (i == 3));
      check("t1_raddr", bus.raddr, 3);
      check("t1_rd_id", bus.rd_id, 5);
      check("t1_rready", bus.rready, 1);
      check("t1_cmd_ready_busy", bus.cmd_ready, 0);
      if (i > 0) begin
        check("t1_row_valid", bus.row_valid, 1);
        check("t1_row_idx", bus.row_idx, i - 1);
        check("t1_row_last", bus.row_last, 0);
      end
      cyc();
    end
    check("t1_last_idx", bus.row_idx, 3);
    check("t1_last_flag", bus.row_last, 1);
    check("t1_drain_rready", bus.rready, 0);
    check("t1_done_early", done_o, 0);
    cyc();
    check("t1_done", done_o, 1);
    check("t1_busy_drain", busy_o, 1);
    cyc();
    check("t1_done_pulse", done_o, 0);
    check("t1_idle_ready", bus.cmd_ready, 1);
    check("t1_npop", pop_idx.size(), 4);
    for (int i = 0; i < 4 && i < pop_idx.size(); i++) check("t1_order", pop_idx[i], i);

    // Test 2: two rows with a 3-cycle stall on row 1
    pop_idx.delete();
    issue(3'd6, 4'd9, 3'd2);
    cyc();
    bus.cmd_valid = 1'b0;
    check("t2_row0", bus.rrowaddr, 0);
    check("t2_rlast0", bus.rlast, 0);
    cyc();
    bus.rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_raddr", bus.raddr, 6);
      check("t2_hold_row", bus.rrowaddr, 1);
      check("t2_hold_rlast", bus.rlast, 1);
      check("t2_hold_rready", bus.rready, 1);
      cyc();
    end
    bus.rvalid = 1'b1;
    check("t2_resume_row", bus.rrowaddr, 1);
    cyc();
`ifdef QUADRILATERO_RD_STREAMER_STATS_EN
    check("t2_stall", stall_cycles_o, 3);
`else
    check("t2_stall", stall_cycles_o, 0);
`endif
    wait_done("t2_done");
    cyc();
    check("t2_npop", pop_idx.size(), 2);
    for (int i = 0; i < 2 && i < pop_idx.size(); i++) check("t2_order", pop_idx[i], i);
`ifdef QUADRILATERO_RD_STREAMER_STATS_EN
    check("t2_stall_held", stall_cycles_o, 3);
`endif

    // Test 3: backpressure fills the FIFO; second command waits for done
    pop_idx.delete();
    grants = 0;
    bus.row_ready = 1'b0;
    issue(3'd1, 4'd2, 3'd4);
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    cyc();
    check("t3_full_rready", bus.rready, 0);
    check("t3_full_row", bus.rrowaddr, 2);
    bus.cmd_valid = 1'b1;
    bus.cmd_reg   = 3'd7;
    bus.cmd_id    = 4'd4;
    bus.cmd_nrows = 3'd1;
    for (int k = 0; k < 3; k++) begin
      check("t3_cmd_blocked", bus.cmd_ready, 0);
      check("t3_stay_low", bus.rready, 0);
      cyc();
    end
    check("t3_grants2", grants, 2);
    bus.row_ready = 1'b1;
    wait_done("t3_done");
    check("t3_raddr_kept", bus.raddr, 1);
    check("t3_grants4", grants, 4);
    check("t3_npop", pop_idx.size(), 4);
    for (int i = 0; i < 4 && i < pop_idx.size(); i++) check("t3_order", pop_idx[i], i);
    cur_reg = 3'd7;
    cyc();
    check("t3_idle_ready", bus.cmd_ready, 1);
    cyc();
    bus.cmd_valid = 1'b0;
    check("t3_new_raddr", bus.raddr, 7);
    check("t3_new_row", bus.rrowaddr, 0);
    check("t3_new_rlast", bus.rlast, 1);
    check("t3_new_id", bus.rd_id, 4);
    wait_done("t3_done2");
    cyc();

    // Test 4: reset after the grant of row 1
    bus.row_ready = 1'b0;
    issue(3'd5, 4'd3, 3'd4);
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    cyc();
    rst_i = 1'b1;
    #1;
    check("t4_cmd_ready", bus.cmd_ready, 1);
    check("t4_rready", bus.rready, 0);
    check("t4_rlast", bus.rlast, 0);
    check("t4_raddr", bus.raddr, 0);
    check("t4_rrowaddr", bus.rrowaddr, 0);
    check("t4_rd_id", bus.rd_id, 0);
    check("t4_row_valid", bus.row_valid, 0);
    check("t4_row_data", bus.row_data, 0);
    check("t4_row_idx", bus.row_idx, 0);
    check("t4_row_last", bus.row_last, 0);
    check("t4_busy", busy_o, 0);
    check("t4_done", done_o, 0);
    check("t4_stall", stall_cycles_o, 0);
    cyc();
    rst_i = 1'b0;
    pop_idx.delete();
    bus.row_ready = 1'b1;
    issue(3'd2, 4'd1, 3'd1);
    cyc();
    bus.cmd_valid = 1'b0;
    check("t4_new_raddr", bus.raddr, 2);
    check("t4_new_row", bus.rrowaddr, 0);
    check("t4_new_rlast", bus.rlast, 1);
    wait_done("t4_done_new");
    cyc();
    check("t4_npop", pop_idx.size(), 1);

`ifdef QUADRILATERO_RD_STREAMER_STATS_EN
    // Test 5: stall counter saturation
    bus.rvalid = 1'b0;
    issue(3'd0, 4'd0, 3'd1);
    cyc();
    bus.cmd_valid = 1'b0;
    check("t5_stall_clr", stall_cycles_o, 0);
    repeat (70000) cyc();
    check("t5_stall_sat", stall_cycles_o, 16'hFFFF);
    bus.rvalid = 1'b1;
    cyc();
    wait_done("t5_done");
    cyc();
    check("t5_stall_held", stall_cycles_o, 16'hFFFF);
    issue(3'd0, 4'd0, 3'd1);
    cyc();
    bus.cmd_valid = 1'b0;
    check("t5_stall_clr2", stall_cycles_o, 0);
    wait_done("t5_done2");
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
